lsu_mem_port: RTL

- Load/store responder between the core's decoded memory controls (RAM_read_en, RAM_write_en, RAM_ram_type, RAM_sign) and a single-port data-memory bus.
- Converts byte-addressed byte/halfword/word requests into word-aligned bus transactions with byte enables.
- Performs the read handshake, then lane extraction and sign/zero extension.
- Stalls the core until the access completes or faults.

---
 rtl/lsu_mem_port_pkg.sv | 29 ++
 rtl/lsu_mem_port_if.sv | 20 ++
 rtl/lsu_mem_port_lane_align.sv | 52 +++++
 rtl/lsu_mem_port.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// rtl/lsu_mem_port_pkg.sv - shared size codes, state encoding and fault causes for the LSU memory port
package lsu_mem_port_pkg;

  localparam logic [3:0] RAM_BYTE     = 4'b0001;
  localparam logic [3:0] RAM_HALFWORD = 4'b0010;
  localparam logic [3:0] RAM_FULLWORD = 4'b0100;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_e;

  function automatic logic is_legal_size(input logic [3:0] ram_type);
    return (ram_type == RAM_BYTE) || (ram_type == RAM_HALFWORD) || (ram_type == RAM_FULLWORD);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] ram_type, input logic [1:0] addr_lo);
    return ((ram_type == RAM_HALFWORD) && addr_lo[0]) ||
           ((ram_type == RAM_FULLWORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - single-port data-memory bus between the LSU (master) and memory (slave)
interface lsu_mem_port_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/lsu_mem_port_lane_align.sv
// rtl/lsu_mem_port_lane_align.sv - byte-enable generation, store lane replication and load extract/extend
import lsu_mem_port_pkg::*;

module lsu_lane_align (
  input  logic [3:0]  ram_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = mem_rdata_i[7:0];
      2'd1:    byte_lane = mem_rdata_i[15:8];
      2'd2:    byte_lane = mem_rdata_i[23:16];
      default: byte_lane = mem_rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = mem_rdata_i;
    case (ram_type_i)
      RAM_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
      end
      RAM_HALFWORD: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & half_lane[15]}}, half_lane};
      end
      RAM_FULLWORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store responder: validates, issues one bus transaction, returns extended data
import lsu_mem_port_pkg::*;

module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [3:0]        ram_type_i,
  input  logic              sign_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  lsu_mem_port_if.master    mem
);

  lsu_state_e  state_q;
  logic [1:0]  addr_lo_q;
  logic [3:0]  type_q;
  logic        sign_q;
  logic        we_q;
  logic [CNT_W-1:0] cnt_q;

  logic        done_q;
  logic        err_q;
  logic [1:0]  cause_q;
  logic [31:0] rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        in_idle;
  logic        access_d;
  logic [3:0]  al_type;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign in_idle  = (state_q == ST_IDLE);
  assign access_d = re_i | we_i;

  // In IDLE the aligner sees the incoming request so the bus fields can be registered on entry to REQ;
  // afterwards it sees the latched request so the load extract uses the original address and size.
  assign al_type    = in_idle ? ram_type_i  : type_q;
  assign al_addr_lo = in_idle ? addr_i[1:0] : addr_lo_q;

  lsu_lane_align u_align (
    .ram_type_i  (al_type),
    .addr_lo_i   (al_addr_lo),
    .sign_i      (sign_q),
    .wdata_i     (wdata_i),
    .mem_rdata_i (mem.rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      type_q      <= 4'b0000;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cause_q     <= ERR_NONE;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_d) begin
            addr_lo_q <= addr_i[1:0];
            type_q    <= ram_type_i;
            sign_q    <= sign_i;
            we_q      <= we_i;
            if ((re_i & we_i) || !is_legal_size(ram_type_i)) begin
              state_q <= ST_FAULT;
              err_q   <= 1'b1;
              cause_q <= ERR_ILLEGAL;
            end else if (is_misaligned(ram_type_i, addr_i[1:0])) begin
              state_q <= ST_FAULT;
              err_q   <= 1'b1;
              cause_q <= ERR_MISALIGNED;
            end else begin
              state_q     <= ST_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_i;
              mem_be_q    <= al_be;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_wdata_q <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem.ready || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
          end
          if (mem.ready) begin
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            rdata_q <= we_q ? 32'h0 : al_rdata;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_FAULT;
            err_q   <= 1'b1;
            cause_q <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
          cause_q <= ERR_NONE;
        end
      endcase
    end
  end

  // IDLE stalls combinationally so the core holds the request in the very cycle it is presented.
  assign stall_o     = in_idle ? access_d : (state_q == ST_REQ);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign err_cause_o = cause_q;

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.be    = mem_be_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;

endmodule
